// File: rtl/seg_scan_capture_if.sv
// Multiplexed 7-segment scan bus: one-hot digit select plus shared segment byte.
interface seg_scan_capture_if;
  logic [5:0] seg_sel;
  logic [7:0] seg_data;

  modport master (output seg_sel, output seg_data);
  modport slave  (input  seg_sel, input  seg_data);
endinterface

// File: rtl/seg_scan_capture.sv
// Rebuilds six multiplexed 7-segment digits from the scan bus and decodes each
// captured glyph back to hex value, decimal point, legality and freshness.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter bit          SEL_ACTIVE_LOW = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  seg_scan_capture_if.slave i_bus,
  output logic [47:0]       o_seg_raw,
  output logic [23:0]       o_bin_data,
  output logic [5:0]        o_dot,
  output logic [5:0]        o_known,
  output logic [5:0]        o_fresh,
  output logic              o_capture_stb,
  output logic              o_frame_done
);
  localparam int unsigned   SW           = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned   TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [5:0]    SEL_FLIP     = {6{SEL_ACTIVE_LOW}};
  localparam logic [7:0]    SEG_FLIP     = {8{SEG_ACTIVE_LOW}};

  function automatic logic f_is_onehot(input logic [5:0] sel);
    return (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
  endfunction

  // Returns {known, hex}; any pattern outside the glyph set decodes to zero.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h10;
      7'h06:   res = 5'h11;
      7'h5B:   res = 5'h12;
      7'h4F:   res = 5'h13;
      7'h66:   res = 5'h14;
      7'h6D:   res = 5'h15;
      7'h7D:   res = 5'h16;
      7'h07:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h6F:   res = 5'h19;
      7'h77:   res = 5'h1A;
      7'h7C:   res = 5'h1B;
      7'h39:   res = 5'h1C;
      7'h5E:   res = 5'h1D;
      7'h79:   res = 5'h1E;
      7'h71:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [5:0]    r_sel_q1, r_sel_q2, r_prev_sel, r_mask;
  logic [7:0]    r_data_q1, r_data_q2, r_prev_data;
  logic [SW-1:0] r_stab;
  logic [TW-1:0] r_tmo [6];
  logic [47:0]   r_seg_raw;
  logic [23:0]   r_bin_data;
  logic [5:0]    r_dot, r_known, r_fresh;
  logic          r_capture_stb, r_frame_done;

  logic [5:0]    w_sel, w_cap_vec, w_mask_nxt;
  logic [7:0]    w_data;
  logic          w_valid, w_same, w_cap;
  logic [SW-1:0] w_stab_nxt;
  logic [4:0]    w_dec;

  // Normalise the sample, run the stability counter and pick the capture.
  always_comb begin
    w_sel   = r_sel_q2 ^ SEL_FLIP;
    w_data  = r_data_q2 ^ SEG_FLIP;
    w_valid = f_is_onehot(w_sel);
    w_same  = (w_sel == r_prev_sel) && (w_data == r_prev_data);
    if (!w_valid) begin
      w_stab_nxt = '0;
    end else if (!w_same) begin
      w_stab_nxt = SW'(1);
    end else if (r_stab != STABLE_MAX) begin
      w_stab_nxt = r_stab + SW'(1);
    end else begin
      w_stab_nxt = r_stab;
    end
    // A saturated counter on an unchanged sample means this window already fired.
    w_cap      = w_valid && (w_stab_nxt == STABLE_MAX) && !(w_same && (r_stab == STABLE_MAX));
    w_cap_vec  = w_cap ? w_sel : 6'd0;
    w_dec      = f_decode(w_data[6:0]);
    w_mask_nxt = r_mask | w_cap_vec;
  end

  // Input pipeline, capture registers, freshness timers and frame tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sel_q1      <= 6'd0;
      r_sel_q2      <= 6'd0;
      r_data_q1     <= 8'd0;
      r_data_q2     <= 8'd0;
      r_prev_sel    <= 6'd0;
      r_prev_data   <= 8'd0;
      r_stab        <= '0;
      r_mask        <= 6'd0;
      r_seg_raw     <= 48'd0;
      r_bin_data    <= 24'd0;
      r_dot         <= 6'd0;
      r_known       <= 6'd0;
      r_fresh       <= 6'd0;
      r_capture_stb <= 1'b0;
      r_frame_done  <= 1'b0;
      for (int n = 0; n < 6; n++) begin
        r_tmo[n] <= '0;
      end
    end else begin
      r_sel_q1      <= i_bus.seg_sel;
      r_sel_q2      <= r_sel_q1;
      r_data_q1     <= i_bus.seg_data;
      r_data_q2     <= r_data_q1;
      r_prev_sel    <= w_sel;
      r_prev_data   <= w_data;
      r_stab        <= w_stab_nxt;
      r_capture_stb <= w_cap;
      if (w_mask_nxt == 6'h3F) begin
        r_mask       <= 6'd0;
        r_frame_done <= 1'b1;
      end else begin
        r_mask       <= w_mask_nxt;
        r_frame_done <= 1'b0;
      end
      for (int n = 0; n < 6; n++) begin
        if (w_cap_vec[n]) begin
          r_seg_raw[8*n +: 8]  <= w_data;
          r_bin_data[4*n +: 4] <= w_dec[3:0];
          r_known[n]           <= w_dec[4];
          r_dot[n]             <= w_data[7];
          r_fresh[n]           <= 1'b1;
          r_tmo[n]             <= TIMEOUT_LOAD;
        end else if (r_tmo[n] != '0) begin
          r_tmo[n] <= r_tmo[n] - TW'(1);
          if (r_tmo[n] == TW'(1)) begin
            r_fresh[n] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_seg_raw     = r_seg_raw;
  assign o_bin_data    = r_bin_data;
  assign o_dot         = r_dot;
  assign o_known       = r_known;
  assign o_fresh       = r_fresh;
  assign o_capture_stb = r_capture_stb;
  assign o_frame_done  = r_frame_done;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: expected captures queue up as the bus is
// driven and are checked on each capture strobe, alongside timing/timeout/reset checks.
module tb_seg_scan_capture;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_capture_if bus ();
  seg_scan_capture_if bus_p ();

  logic [47:0] seg_raw, p_seg_raw;
  logic [23:0] bin_data, p_bin_data;
  logic [5:0]  dot, known, fresh, p_dot, p_known, p_fresh;
  logic        cap_stb, frame_done, p_cap_stb, p_frame_done;

  seg_scan_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(200),
                     .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_bus(bus),
    .o_seg_raw(seg_raw), .o_bin_data(bin_data), .o_dot(dot), .o_known(known),
    .o_fresh(fresh), .o_capture_stb(cap_stb), .o_frame_done(frame_done));

  seg_scan_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(200),
                     .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_bus(bus_p),
    .o_seg_raw(p_seg_raw), .o_bin_data(p_bin_data), .o_dot(p_dot), .o_known(p_known),
    .o_fresh(p_fresh), .o_capture_stb(p_cap_stb), .o_frame_done(p_frame_done));

  typedef struct packed {
    logic [2:0] d;
    logic [7:0] raw;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0, n_fail = 0;
  int n_stb = 0, n_frame = 0;
  int cyc = 0, frame_cyc = -1, stb_cyc = -1, fall_cyc = -1, k_drive = 0;
  int cap_cyc [6];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_dec(input logic [7:0] raw);
    for (int i = 0; i < 16; i++) begin
      if (GLYPH[i] == raw[6:0]) return {1'b1, 4'(i)};
    end
    return 5'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [7:0] data, input int dwell, input bit exp_cap);
    exp_t e;
    bus.seg_sel  = 6'(1 << d);
    bus.seg_data = data;
    k_drive      = cyc;
    if (exp_cap) begin
      e.d = 3'(d);
      e.raw = data;
      sb_q.push_back(e);
    end
    tick(dwell);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor on the falling edge.
  initial begin
    exp_t e;
    logic [4:0] m;
    logic prev_f4;
    prev_f4 = 1'b0;
    forever begin
      @(negedge clk);
      if (cap_stb === 1'b1) begin
        n_stb++;
        stb_cyc = cyc;
        chk("sb_nonempty", 48'(sb_q.size() != 0), 48'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          m = model_dec(e.raw);
          cap_cyc[e.d] = cyc;
          chk("cap_raw",   48'(seg_raw[8*e.d +: 8]),  48'(e.raw));
          chk("cap_bin",   48'(bin_data[4*e.d +: 4]), 48'(m[3:0]));
          chk("cap_known", 48'(known[e.d]),           48'(m[4]));
          chk("cap_dot",   48'(dot[e.d]),             48'(e.raw[7]));
          chk("cap_fresh", 48'(fresh[e.d]),           48'd1);
        end
      end
      if (frame_done === 1'b1) begin
        n_frame++;
        frame_cyc = cyc;
      end
      if (prev_f4 === 1'b1 && fresh[4] === 1'b0) fall_cyc = cyc;
      prev_f4 = fresh[4];
    end
  end

  initial begin
    int s0, f0, f1;
    bus_p.seg_sel  = 6'h3F;
    bus_p.seg_data = 8'hFF;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.seg_sel  = 6'(1 << i);
      bus.seg_data = 8'(8'h35 + 8'(i * 17));
      tick(1);
    end
    chk("rst_raw", seg_raw, 48'd0);
    chk("rst_outs", {4'd0, bin_data, dot, known, fresh, cap_stb, frame_done}, 48'd0);
    chk("rst_p_outs", {p_seg_raw[23:0], p_bin_data}, 48'd0);
    chk("rst_no_stb_frame", 48'(n_stb + n_frame), 48'd0);

    bus.seg_sel = 6'd0;
    bus.seg_data = 8'd0;
    rst = 1'b1;
    tick(5);

    s0 = n_stb; f0 = n_frame;
    for (int d = 0; d < 6; d++) show(d, {1'b0, GLYPH[d]}, 100, 1'b1);
    chk("scan_stb_count", 48'(n_stb - s0), 48'd6);
    chk("scan_frame_count", 48'(n_frame - f0), 48'd1);
    chk("scan_frame_cycle", 48'(frame_cyc), 48'(k_drive + 18));
    chk("scan_bin", 48'(bin_data), 48'h543210);
    chk("scan_known", 48'(known), 48'h3F);
    chk("scan_dot", 48'(dot), 48'd0);

    s0 = n_stb;
    bus.seg_sel = 6'b000011;
    bus.seg_data = 8'h06;
    tick(30);
    chk("multihot_nocap", 48'(n_stb - s0), 48'd0);
    show(3, 8'h4F, 6, 1'b0);
    bus.seg_sel = 6'b000011;
    tick(3);
    show(3, 8'h4F, 6, 1'b0);
    show(3, 8'h7F, 10, 1'b0);
    show(3, 8'h4F, 40, 1'b1);
    chk("ghost_one_cap", 48'(n_stb - s0), 48'd1);
    chk("ghost_cap_cycle", 48'(stb_cyc), 48'(k_drive + 18));
    chk("ghost_raw3", 48'(seg_raw[31:24]), 48'h4F);

    show(2, 8'hFF, 30, 1'b1);
    chk("dot2", 48'(dot[2]), 48'd1);
    chk("ff_bin2", 48'(bin_data[11:8]), 48'd8);
    chk("ff_known2", 48'(known[2]), 48'd1);
    show(2, 8'h49, 30, 1'b1);
    chk("ill_known2", 48'(known[2]), 48'd0);
    chk("ill_bin2", 48'(bin_data[11:8]), 48'd0);
    chk("ill_raw2", 48'(seg_raw[23:16]), 48'h49);

    for (int i = 0; i < 16; i++) show(1, {i[0], GLYPH[i]}, 24, 1'b1);
    chk("sweep_bin1", 48'(bin_data[7:4]), 48'hF);

    bus_p.seg_sel = 6'b111110;
    bus_p.seg_data = 8'hC0;
    tick(30);
    chk("pol_raw0", 48'(p_seg_raw[7:0]), 48'h3F);
    chk("pol_bin0", 48'(p_bin_data[3:0]), 48'd0);
    chk("pol_known0", 48'(p_known[0]), 48'd1);
    chk("pol_dot0", 48'(p_dot[0]), 48'd0);
    bus_p.seg_sel = 6'h3F;
    bus_p.seg_data = 8'hFF;

    fall_cyc = -1;
    show(0, {1'b0, GLYPH[0]}, 24, 1'b1);
    show(1, {1'b0, GLYPH[1]}, 24, 1'b1);
    show(2, {1'b0, GLYPH[2]}, 24, 1'b1);
    show(3, {1'b0, GLYPH[3]}, 24, 1'b1);
    show(5, {1'b0, GLYPH[5]}, 24, 1'b1);
    show(4, {1'b0, GLYPH[4]}, 24, 1'b1);
    for (int r = 0; r < 2; r++) begin
      show(0, {1'b0, GLYPH[0]}, 24, 1'b1);
      show(1, {1'b0, GLYPH[1]}, 24, 1'b1);
      show(2, {1'b0, GLYPH[2]}, 24, 1'b1);
      show(3, {1'b0, GLYPH[3]}, 24, 1'b1);
      show(5, {1'b0, GLYPH[5]}, 24, 1'b1);
    end
    chk("tmo_fall_cycle", 48'(fall_cyc), 48'(cap_cyc[4] + 200));
    chk("tmo_fresh_mask", 48'(fresh), 48'h2F);

    rst = 1'b0;
    bus.seg_sel = 6'd0;
    tick(3);
    rst = 1'b1;
    tick(3);
    for (int d = 0; d < 3; d++) show(d, {1'b0, GLYPH[d]}, 24, 1'b1);
    f0 = n_frame;
    rst = 1'b0;
    bus.seg_sel = 6'd0;
    tick(3);
    rst = 1'b1;
    chk("midrst_fresh_known", 48'({fresh, known}), 48'd0);
    tick(3);
    f1 = n_frame;
    show(3, {1'b0, GLYPH[3]}, 24, 1'b1);
    show(4, {1'b0, GLYPH[4]}, 24, 1'b1);
    show(5, {1'b0, GLYPH[5]}, 24, 1'b1);
    chk("midrst_no_early_frame", 48'(n_frame - f1), 48'd0);
    for (int d = 0; d < 3; d++) show(d, {1'b0, GLYPH[d]}, 24, 1'b1);
    chk("midrst_frame_count", 48'(n_frame - f0), 48'd1);
    chk("midrst_frame_cycle", 48'(frame_cyc), 48'(k_drive + 18));
    chk("sb_drained", 48'(sb_q.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the display scanner.
- Watches the multiplexed 7-segment bus (one-hot digit select plus shared segment byte) and rebuilds the six per-digit segment bytes.
- Decodes each byte back to a 4-bit hex value plus decimal point.
- Used as an on-chip loopback/self-check monitor and as the bench-side checker for the display path.

Parameters:
- STABLE_CYCLES, 16: consecutive identical (sel, data) samples required before a digit is captured.
- TIMEOUT_CYCLES, 1_000_000: cycles without a capture after which a digit's fresh flag drops.
- SEL_ACTIVE_LOW, 0: 1 = seg_sel is active-low one-hot.
- SEG_ACTIVE_LOW, 0: 1 = seg_data segments and dot are active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- seg_sel  in  6  digit select, one-hot (bit n = digit n)
- seg_data  in  8  segments: bit7 = dot, bits6:0 = g,f,e,d,c,b,a
- seg_raw  out  48  captured bytes, digit n at [8n+7:8n], polarity-normalised (1 = lit)
- bin_data  out  24  decoded hex, digit n at [4n+3:4n]
- dot  out  6  decoded decimal point per digit
- known  out  6  1 = captured pattern is one of the 16 legal glyphs
- fresh  out  6  1 = digit captured within the last TIMEOUT_CYCLES
- capture_stb  out  1  one-cycle pulse on any digit capture
- frame_done  out  1  one-cycle pulse when all six digits have been captured since the previous pulse

Behaviour:
- Reset (rst=0 at a clk edge) clears to 0:
  - all outputs;
  - the input pipeline;
  - the stability counter;
  - the per-digit timeout counters;
  - the frame-seen mask.
- Reset mid-operation discards any partial capture and the frame progress.
- Input stage:
  - seg_sel and seg_data are registered twice (2 cycles latency).
  - They are then normalised by XOR with the polarity parameters, so internally 1 = active/lit.
- Validity: a normalised sample is valid only when sel is exactly one-hot. All-zero or multi-hot (ghosting during digit changeover) is invalid.
- Stability counter, width ceil(log2(STABLE_CYCLES+1)):
  - Resets to 1 when the current sample differs from the previous sample.
  - Resets to 0 on an invalid sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - Capture happens on the cycle the counter reaches STABLE_CYCLES (transition from STABLE_CYCLES-1), once per stable window.
  - A longer dwell gives no repeat capture until the sample changes.
- Capture of digit n, with all updates in the same cycle:
  - seg_raw[n] <= data;
  - bin_data[n] and known[n] from the decode table;
  - dot[n] <= data[7];
  - fresh[n] <= 1 and the timeout counter of n is reloaded;
  - capture_stb <= 1;
  - n is set in the frame-seen mask.
- Latency: a digit appears 2 + STABLE_CYCLES cycles after its bus value settles.
- Decode table, bits6:0 to hex:

  | Hex | bits6:0 |
  |-----|---------|
  | 0 | 3F |
  | 1 | 06 |
  | 2 | 5B |
  | 3 | 4F |
  | 4 | 66 |
  | 5 | 6D |
  | 6 | 7D |
  | 7 | 07 |
  | 8 | 7F |
  | 9 | 6F |
  | A | 77 |
  | b | 7C |
  | C | 39 |
  | d | 5E |
  | E | 79 |
  | F | 71 |

  - Any other pattern: bin_data = 0, known = 0, seg_raw still updated.
- Timeout counters:
  - One per digit; each decrements every cycle while nonzero.
  - When a counter reaches 0, fresh[n] drops to 0 the same cycle.
  - A capture and an expiry of the same digit in the same cycle: the capture wins.
- frame_done:
  - When the mask (including the digit being captured this cycle) becomes 6'b111111, frame_done pulses on that cycle and the mask clears.
  - Recapturing an already-seen digit does not pulse frame_done.
  - Digit order is irrelevant.
- No back-pressure; outputs hold until the next capture of the same digit.

Test Plan:
- Reset hold (rst=0 for 5 clocks with the bus toggling) -> all outputs 0, no capture_stb, no frame_done.
- Scan digits 0..5, each showing the glyph for its own index (3F, 06, 5B, 4F, 66, 6D), dwell 100 cycles each, no dot:
  - -> bin_data = 24'h543210, known = 6'h3F, dot = 0;
  - -> exactly 6 capture_stb pulses;
  - -> 1 frame_done pulse on the 6th capture, at cycle 2+16 into the digit-5 dwell.
- Ghosting: insert 3 cycles of sel = 6'b000011, then a 10-cycle glitch to a different data value mid-dwell:
  - -> no capture from the multi-hot sel;
  - -> the glitch value is not captured (shorter than STABLE_CYCLES);
  - -> the good value is recaptured only after 16 stable cycles.
- Dot and illegal glyphs:
  - digit 2 driven 8'hFF -> dot[2] = 1, bin_data[11:8] = 8, known[2] = 1;
  - digit 2 driven 8'h49 -> known[2] = 0, bin_data[11:8] = 0, seg_raw[23:16] = 8'h49.
- Polarity: SEL_ACTIVE_LOW = 1, SEG_ACTIVE_LOW = 1, drive sel = 6'b111110, data = 8'hC0 (inverted 3F) -> seg_raw[7:0] = 8'h3F, bin_data[3:0] = 0.
- Timeout and reset mid-frame, with TIMEOUT_CYCLES = 200:
  - stop refreshing digit 4 -> fresh[4] falls exactly 200 cycles after its last capture while other digits stay 1;
  - rst low after 3 of 6 digits captured, then a full scan -> frame_done only after all 6 new captures.
